// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field layout, FSM encoding and the legal-opcode decode.
package alu_pkg;

  localparam int NREGS_DEF = 16;
  localparam int DW_DEF    = 32;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_ADC   = 8'h21;
  localparam logic [7:0] OP_INCA  = 8'h23;
  localparam logic [7:0] OP_DECA  = 8'h24;
  localparam logic [7:0] OP_SUB   = 8'h25;
  localparam logic [7:0] OP_RSUB  = 8'h26;
  localparam logic [7:0] OP_AND   = 8'h28;
  localparam logic [7:0] OP_OR    = 8'h29;
  localparam logic [7:0] OP_ZEROS = 8'h30;
  localparam logic [7:0] OP_ONES  = 8'h3F;

  // instruction word layout
  localparam int F_OP      = 24;
  localparam int F_RD      = 20;
  localparam int F_RA      = 16;
  localparam int F_RB      = 12;
  localparam int F_IMM_SEL = 11;
  localparam int IMM_W     = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // latched instruction, legality decoded once at acceptance
  typedef struct packed {
    logic [7:0]       op;
    logic [3:0]       rd;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic             legal;
  } issue_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_INCA, OP_DECA,
      OP_SUB, OP_RSUB, OP_AND, OP_OR: return 1'b1;
      default:                        return (op >= OP_ZEROS) && (op <= OP_ONES);
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: one synchronous write port, two combinational
// read ports and a debug read port. r0 is hardwired to zero.
module alu_regfile #(
  parameter  int NREGS = 16,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [NREGS-1:0][DW-1:0] mem;

  // storage; writes to r0 are dropped so it never leaves zero
  always_ff @(posedge clock) begin
    if (reset)                    mem <= '0;
    else if (we && waddr != '0)   mem[waddr] <= wdata;
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the opcode-edge-triggered ALU. Each instruction
// occupies IDLE -> READ -> EXEC -> WB; operands settle one cycle before
// the opcode changes, and NOP is driven between issues so repeated
// opcodes still present an edge to the ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int         NREGS  = NREGS_DEF,
  parameter  int         DW     = DW_DEF,
  parameter  logic [7:0] NOP_OP = OP_NOP,
  localparam int         AW     = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [7:0]    alu_opcode,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_flag,
  output logic          done,
  output logic          illegal,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state, state_nxt;
  issue_t        dec, iq;
  logic          accept;
  logic          wb_we, ld_we;
  logic [DW-1:0] ra_data, rb_data, simm;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign done        = (state == ST_WB);
  assign illegal     = done && !iq.legal;
  assign simm        = {{(DW-IMM_W){iq.imm[IMM_W-1]}}, iq.imm};

  // field split of the incoming word
  always_comb begin
    dec.op      = instr[F_OP +: 8];
    dec.rd      = instr[F_RD +: 4];
    dec.ra      = instr[F_RA +: 4];
    dec.rb      = instr[F_RB +: 4];
    dec.use_imm = instr[F_IMM_SEL];
    dec.imm     = instr[IMM_W-1:0];
    dec.legal   = is_legal_op(instr[F_OP +: 8]);
  end

  // external loads only in an idle cycle with no handshake; WB owns the port otherwise
  assign wb_we = (state == ST_WB) && iq.legal;
  assign ld_we = (state == ST_IDLE) && ld_en && !accept;

  alu_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clock    (clock),
    .reset    (reset),
    .we       (wb_we || ld_we),
    .waddr    (wb_we ? AW'(iq.rd) : ld_addr),
    .wdata    (wb_we ? alu_out : ld_data),
    .ra_addr  (AW'(iq.ra)),
    .ra_data  (ra_data),
    .rb_addr  (AW'(iq.rb)),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // fixed four-cycle walk, leaving IDLE only on a handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
    endcase
  end

  // instruction latch, ALU drive and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      iq         <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= NOP_OP;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) iq <= dec;
        ST_READ: begin
          alu_a      <= ra_data;
          alu_b      <= iq.use_imm ? simm : rb_data;
          alu_opcode <= NOP_OP;
        end
        ST_EXEC: alu_opcode <= iq.legal ? iq.op : NOP_OP;
        ST_WB: begin
          alu_opcode <= NOP_OP;
          if (iq.legal) begin
            flag_z <= (alu_out == '0);
            flag_n <= alu_out[DW-1];
            flag_c <= alu_flag;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue-side controller for the 8-bit-opcode ALU. It accepts one instruction word per valid/ready handshake and reads operands from an internal 16x32 register file.
- It drives the ALU's A/B/opcode inputs using the opcode-edge discipline the ALU requires, then captures the ALU result and writes it back.
- It sits between instruction fetch and the ALU in the processor datapath, and is the producer/consumer end of the ALU's operand/opcode/result interface.

Parameters:
- NREGS, 16, number of architectural registers (address width = log2(NREGS) = 4).
- DW, 32, datapath width; must match the ALU.
- NOP_OP, 8'h00, opcode driven to the ALU when idle; not a legal ALU opcode.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word presented.
- instr_ready  out  1  controller can accept an instruction (high only in IDLE).
- instr  in  32  [31:24] op, [23:20] rd, [19:16] ra, [15:12] rb, [11] use_imm, [10:0] imm11.
- ld_en  in  1  external register load strobe (boot/test).
- ld_addr  in  4  load target register.
- ld_data  in  32  load data.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_opcode  out  8  ALU opcode.
- alu_out  in  32  ALU result.
- alu_flag  in  1  ALU flag output.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse with done: op was not a legal ALU opcode.
- flag_z  out  1  last legal result == 0.
- flag_n  out  1  last legal result bit 31.
- flag_c  out  1  alu_flag captured on the last legal op.
- dbg_addr  in  4  debug read address.
- dbg_data  out  32  combinational read of the register file at dbg_addr (r0 reads 0).

Behaviour:
- Reset (synchronous):
  - state=IDLE; alu_a=alu_b=0; alu_opcode=NOP_OP.
  - done=illegal=0; flag_z=flag_n=flag_c=0.
  - All registers cleared to 0.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. Fixed 4-cycle occupancy per instruction.
- Cycle 0, IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch op/rd/ra/rb/use_imm/imm11, decode legality, go to READ.
- Cycle 1, READ:
  - alu_a <= R[ra].
  - alu_b <= use_imm ? sign_extend(imm11) : R[rb].
  - alu_opcode held at NOP_OP.
  - This guarantees operands are stable before the opcode edge, because the ALU evaluates only on opcode change.
- Cycle 2, EXEC: alu_opcode <= legal ? op : NOP_OP.
- Cycle 3, WB:
  - Sample alu_out and alu_flag.
  - If legal and rd!=0: R[rd] <= alu_out.
  - flag_z, flag_n and flag_c updated from alu_out and alu_flag, only if legal.
  - done=1; illegal=!legal.
  - alu_opcode <= NOP_OP on exit to IDLE.
- Legal opcode set:
  - 0x20, 0x21, 0x23, 0x24, 0x25, 0x26, 0x28, 0x29.
  - 0x30 through 0x3F.
  - Everything else is illegal: no ALU drive, no writeback, flags unchanged.
- r0 reads as 0 and writes to it are discarded, including via ld_en.
- ld_en:
  - Honoured only in IDLE, and only when no instruction is accepted in the same cycle; otherwise ignored.
  - If ld_en and an instruction handshake coincide, the instruction wins and the load is dropped.
- Operand read in READ sees the register file as of that cycle. Back-to-back dependent instructions are therefore always correct, since WB completes before the next READ.
- instr_valid while not IDLE: ignored (ready=0). The source holds instr until accepted.
- Reset asserted in any state: returns to IDLE next edge, aborts writeback, drives NOP_OP, clears all registers.
- Consecutive identical opcodes still produce an ALU edge because NOP_OP is driven between them.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD=8'h20 ... OP_ONES=8'h3F, OP_NOP=8'h00);
  - instruction field bit positions;
  - FSM state encoding (2 bits);
  - function is_legal_op(op).
- One natural sub-module: alu_regfile (16x32, one synchronous write port, two combinational read ports plus a debug port, r0 hardwired zero). The write port is muxed between WB and ld_en.

Test Plan:
- Load/add: ld R1=5, R2=7; issue op 0x20 rd=3 ra=1 rb=2. Required: done at cycle 3 after acceptance, R3=12, flag_z=0, flag_n=0; alu_opcode sequence 00,00,20,00.
- Immediate and negative result: R1=3; op 0x25 rd=4 ra=1 use_imm=1 imm11=0x005. Required: R4=0xFFFFFFFE, flag_n=1, flag_z=0.
- Illegal op: R5=9 preloaded; op 0x22 rd=5. Required: done=1 with illegal=1, R5 stays 9, flags unchanged, alu_opcode never 0x22.
- Back-to-back identical ops: two op 0x23 (inca) rd=1 ra=1, R1=0 initially, instr_valid held high. Required: R1=2; instr_ready low for 3 cycles between accepts; opcode returns to 00 between issues.
- r0 and zero flag: op 0x30 (zeros) rd=0; then op 0x35 (passa) rd=6 ra=0. Required: R0 reads 0; R6=0, flag_z=1.
- Reset mid-op: assert reset during EXEC of op 0x20 rd=3. Required: no write to R3, done never pulses, next cycle state IDLE, instr_ready=1, alu_opcode=00, dbg_data for any address = 0.
